// File: rtl/uart_tx_flow.sv
// UART transmitter for the BNN result path: one-byte holding buffer, RTS-gated frame start.
// Frame is 8N1 by default; define UART_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_flow #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       uart_rts_n,
    output logic       uart_tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BAUD_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                stop_q, stop_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
`ifdef UART_PARITY_EN
    logic                par_q, par_d;
`endif
    logic                rts_meta_q, rts_sync_q;
    logic                tx_line_q, tx_line_d;
    logic                tx_ready_q, tx_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                rts_ok;
    logic                baud_last;
    logic                start_ok;
    logic                load;

    assign rts_ok     = ~rts_sync_q;
    assign tx_ready   = tx_ready_q;
    assign uart_tx    = tx_line_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Two-flop synchronizer for the host RTS pin; resets to "host not ready".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_meta_q <= 1'b1;
            rts_sync_q <= 1'b1;
        end else begin
            rts_meta_q <= uart_rts_n;
            rts_sync_q <= rts_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_q       <= 1'b0;
`endif
            tx_line_q   <= 1'b1;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`ifdef UART_PARITY_EN
            par_q       <= par_d;
`endif
            tx_line_q   <= tx_line_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`ifdef UART_PARITY_EN
        par_d       = par_q;
`endif
        load        = 1'b0;
        baud_last   = (baud_q == BAUD_LAST);
        start_ok    = hold_full_q & rts_ok;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                load   = start_ok;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        stop_d  = 1'b0;
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        load    = start_ok;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        // Buffer-to-shift transfer; taken from IDLE or straight out of the last stop cycle.
        if (load) begin
            state_d     = S_START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            baud_d      = '0;
            bit_d       = '0;
`ifdef UART_PARITY_EN
            par_d       = ^hold_q;
`endif
        end

        // tx_ready is 1 only when the buffer is empty, so this never collides with a transfer.
        if (tx_valid && tx_ready_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_d)
            S_START:  tx_line_d = 1'b0;
            S_DATA:   tx_line_d = shift_d[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_line_d = par_d;
`endif
            default:  tx_line_d = 1'b1;
        endcase

        tx_ready_d = ~hold_full_d;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (stop_d == STOP_LAST);
    end

endmodule

// File: tb/tb_uart_tx_flow.sv
// Bench for uart_tx_flow: two instances (1 and 2 stop bits) against a frame-time reference model.
module tb_uart_tx_flow;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       rts_n;
    logic [1:0] tx_w, ready_w, busy_w, done_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_flow #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[0]), .uart_rts_n(rts_n), .uart_tx(tx_w[0]),
        .busy(busy_w[0]), .frame_done(done_w[0])
    );

    uart_tx_flow #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[1]), .uart_rts_n(rts_n), .uart_tx(tx_w[1]),
        .busy(busy_w[1]), .frame_done(done_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame length in clocks for instance k (k extra stop bits).
    function automatic int flen(input int k);
        return (10 + k + PAR) * CPB;
    endfunction

    // Line level at clock t of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int t);
        int idx;
        idx = t / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[3'(idx - 1)];
        if (PAR == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Reference model: buffer flag, active frame byte and clock offset within the frame.
    logic [1:0] ma_q, ma_d, mh_q, mh_d;
    logic [7:0] mhb_q [2];
    logic [7:0] mhb_d [2];
    logic [7:0] mb_q [2];
    logic [7:0] mb_d [2];
    int         mt_q [2];
    int         mt_d [2];
    logic [1:0] mr_q;

    always_comb begin
        ma_d  = ma_q;
        mh_d  = mh_q;
        mhb_d = mhb_q;
        mb_d  = mb_q;
        mt_d  = mt_q;
        for (int k = 0; k < 2; k++) begin
            if (ma_q[k]) begin
                if (mt_q[k] == flen(k) - 1) ma_d[k] = 1'b0;
                else mt_d[k] = mt_q[k] + 1;
            end
            if ((!ma_q[k] || mt_q[k] == flen(k) - 1) && mh_q[k] && !mr_q[1]) begin
                ma_d[k] = 1'b1;
                mt_d[k] = 0;
                mb_d[k] = mhb_q[k];
                mh_d[k] = 1'b0;
            end
            if (tx_valid && !mh_q[k]) begin
                mh_d[k]  = 1'b1;
                mhb_d[k] = tx_data;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_q <= '0;
            mh_q <= '0;
            mr_q <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                mhb_q[k] <= '0;
                mb_q[k]  <= '0;
                mt_q[k]  <= 0;
            end
        end else begin
            ma_q <= ma_d;
            mh_q <= mh_d;
            mr_q <= {mr_q[0], rts_n};
            for (int k = 0; k < 2; k++) begin
                mhb_q[k] <= mhb_d[k];
                mb_q[k]  <= mb_d[k];
                mt_q[k]  <= mt_d[k];
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("uart_tx[%0d] t=%0d", k, mt_q[k]), 32'(tx_w[k]),
                      32'(ma_q[k] ? exp_bit(mb_q[k], mt_q[k]) : 1'b1));
                check($sformatf("tx_ready[%0d]", k), 32'(ready_w[k]), 32'(!mh_q[k]));
                check($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(ma_q[k]));
                check($sformatf("frame_done[%0d]", k), 32'(done_w[k]),
                      32'(ma_q[k] && mt_q[k] == flen(k) - 1));
            end
        end
    end

    // Busy run lengths and frame_done pulse counts for the directed checks.
    int run_q [2];
    int last_run [2];
    int done_cnt [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                run_q[k] <= 0;
            end else begin
                if (busy_w[k]) begin
                    run_q[k] <= run_q[k] + 1;
                end else if (run_q[k] != 0) begin
                    last_run[k] <= run_q[k];
                    run_q[k]    <= 0;
                end
                if (done_w[k]) done_cnt[k] <= done_cnt[k] + 1;
            end
        end
    end

    task automatic send_one(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (tx_w[0] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({tag, "_start_timeout"}, 32'(n), 32'(0));
    endtask

    int d0, d1, n, lows, busys;

    initial begin
        for (int k = 0; k < 2; k++) begin
            last_run[k] = 0;
            done_cnt[k] = 0;
        end
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        rts_n    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_tx[%0d]", k), 32'(tx_w[k]), 32'(1));
            check($sformatf("rst_ready[%0d]", k), 32'(ready_w[k]), 32'(1));
            check($sformatf("rst_busy[%0d]", k), 32'(busy_w[k]), 32'(0));
            check($sformatf("rst_done[%0d]", k), 32'(done_w[k]), 32'(0));
        end
        idle(3);
        rst_n = 1'b1;
        idle(4);

        // Single frame 0xA5.
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        send_one(8'hA5);
        idle(60);
        check("a5_busy_len0", 32'(last_run[0]), 32'(flen(0)));
        check("a5_busy_len1", 32'(last_run[1]), 32'(flen(1)));
        check("a5_done_cnt0", 32'(done_cnt[0] - d0), 32'(1));
        check("a5_done_cnt1", 32'(done_cnt[1] - d1), 32'(1));

        // Back-to-back 0x01 then 0xFF: no idle gap between frames.
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        send_one(8'h01);
        wait_start("b2b");
        check("b2b_ready_at_start", 32'(ready_w[0]), 32'(1));
        send_one(8'hFF);
        idle(120);
        check("b2b_busy_len0", 32'(last_run[0]), 32'(2 * flen(0)));
        check("b2b_busy_len1", 32'(last_run[1]), 32'(2 * flen(1)));
        check("b2b_done_cnt0", 32'(done_cnt[0] - d0), 32'(2));
        check("b2b_done_cnt1", 32'(done_cnt[1] - d1), 32'(2));

        // Flow control: RTS blocks the start; release latency; mid-frame deassert.
        rts_n = 1'b1;
        idle(4);
        send_one(8'h3C);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_w[0] == 1'b0) lows++;
        end
        check("rts_block_lows", 32'(lows), 32'(0));
        check("rts_block_ready", 32'(ready_w[0]), 32'(0));
        rts_n = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (tx_w[0] == 1'b0) break;
        end
        check("rts_release_latency", 32'(n), 32'(3));
        idle(10);
        rts_n = 1'b1;
        send_one(8'h96);
        idle(100);
        check("rts_hold_busy0", 32'(busy_w[0]), 32'(0));
        check("rts_hold_busy1", 32'(busy_w[1]), 32'(0));
        check("rts_hold_ready0", 32'(ready_w[0]), 32'(0));
        check("rts_hold_ready1", 32'(ready_w[1]), 32'(0));
        rts_n = 1'b0;
        idle(120);

        // Reset in the middle of data bit 3 of 0x55 with a second byte queued.
        send_one(8'h55);
        wait_start("rst");
        send_one(8'hC3);
        idle(15);
        check("pre_rst_bit3", 32'(tx_w[0]), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrst_tx[%0d]", k), 32'(tx_w[k]), 32'(1));
            check($sformatf("midrst_ready[%0d]", k), 32'(ready_w[k]), 32'(1));
            check($sformatf("midrst_busy[%0d]", k), 32'(busy_w[k]), 32'(0));
        end
        idle(2);
        rst_n = 1'b1;
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_w != 2'b11) lows++;
            if (busy_w != 2'b00) busys++;
        end
        check("post_rst_lows", 32'(lows), 32'(0));
        check("post_rst_busy", 32'(busys), 32'(0));

        // Handshake: valid held high with changing data while the buffer is full.
        send_one(8'h11);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        idle(150);

        // Randomized traffic with occasional RTS toggling.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 39) == 0) rts_n = ~rts_n;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        rts_n    = 1'b0;
        idle(200);
        check("drain_busy0", 32'(busy_w[0]), 32'(0));
        check("drain_busy1", 32'(busy_w[1]), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_flow.md
Name: uart_tx_flow

Overview:
- UART transmitter for the BNN result path; drives the chip's UART_Tx pin.
- Accepts result bytes from the BNN controller over a valid/ready handshake and serializes them 8N1, LSB first.
- Holds a one-byte buffer so the next byte can be queued while the current frame is on the line.
- Starts a new frame only while the host's RTS pin (active-low) permits.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  holding buffer empty; byte accepted on a clk edge where tx_valid && tx_ready
- uart_rts_n  input  1  host RTS, active-low; asynchronous to clk
- uart_tx  output  1  serial line, idle high
- busy  output  1  frame in progress (state != IDLE)
- frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (async assert, sync release) forces:
  - uart_tx=1, tx_ready=1, busy=0, frame_done=0
  - holding buffer empty, bit/baud counters 0, state IDLE
  - RTS synchronizer flops = 1 (host not ready)
- Reset asserted mid-frame: line returns high immediately; the in-flight byte and the buffered byte are discarded.
- RTS handling:
  - uart_rts_n passes through a 2-flop synchronizer; rts_ok = ~sync output.
  - Latency from pin to rts_ok is 2 cycles.
- Handshake:
  - tx_ready is registered and equals ~hold_full.
  - On an accept edge, tx_data is captured, hold_full=1, and tx_ready=0 from the next cycle.
  - tx_data/tx_valid are ignored while tx_ready=0; no overwrite.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: uart_tx=1. If hold_full && rts_ok, on that edge: move the buffer to the shift register, clear hold_full, enter START.
    - tx_ready therefore returns to 1 on the first START cycle.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each bit CLKS_PER_BIT cycles. The bit counter runs 0..7; after bit 7, go to PARITY if enabled, otherwise STOP.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 on the final cycle. Next state:
    - If hold_full && rts_ok at that edge, go directly to START with the same buffer transfer as IDLE (zero idle gap).
    - Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, resets at each bit boundary, and is held at 0 in IDLE.
- RTS deasserted mid-frame: the current frame completes unchanged; no new frame starts until rts_ok=1.
- Simultaneous events:
  - Buffer-to-shift transfer and tx_valid on the same edge: the byte is not accepted (tx_ready was 0); it is accepted on the next cycle.
  - rts_ok falling on the same edge as a start decision: the start uses the pre-edge value.
- Frame length is (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles, plus CLKS_PER_BIT if parity is enabled.

Optional Feature:
- Macro UART_PARITY_EN.
  - Defined: PARITY state inserted after D7; uart_tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame is 8E1.
  - Undefined: PARITY state and logic absent; frame is 8N1.

Test Plan:
- CLKS_PER_BIT=4, rts_n=0, send 0xA5 -> uart_tx = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; frame_done pulses once at cycle 40 after start; busy high for 40 cycles.
- Back-to-back: send 0x01 then 0xFF while the first frame is active -> tx_ready returns to 1 on the first START cycle; second start bit immediately follows the first stop bit with no gap; 80 total line cycles.
- Flow control: hold rts_n=1 and send 0x3C -> tx_ready=0, uart_tx stays 1 indefinitely. Drop rts_n to 0 -> start bit begins 3 cycles later (2-flop sync + start edge). Raise rts_n mid-frame -> frame completes; a queued byte waits.
- Reset mid-DATA (bit 3 of 0x55) -> uart_tx=1 within the reset cycle, tx_ready=1, busy=0. After release with no new tx_valid, the line stays idle.
- STOP_BITS=2 -> stop high for 8 cycles; frame 44 cycles. With UART_PARITY_EN: 0xA5 parity bit 0, 0x07 parity bit 1; frame 44 cycles with STOP_BITS=1.
- Handshake: tx_valid held with changing tx_data while tx_ready=0 -> only the byte present on the accept edge is transmitted.
